midi_note_receiver: RTL and testbench

- Serial MIDI front end between the synchronized `midi_din` line and the DRAM read requester's trigger logic.
- Deserializes 31250-baud 8N1 MIDI frames and parses channel-voice messages, including running status.
- Emits one-cycle key/velocity events for Note On messages with non-zero velocity; these events fire the drum instruments.
- Runs entirely in the 100 MHz system domain. The input is already double-flop synchronized upstream.

---
 rtl/midi_note_receiver_pkg.sv | 26 ++
 rtl/midi_note_receiver_if.sv | 21 ++
 rtl/midi_note_receiver_byte_rx.sv | 88 ++++++++
 rtl/midi_note_receiver.sv | 100 ++++++++++
 tb/tb_midi_note_receiver.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/midi_note_receiver_pkg.sv
// MIDI receiver shared package: message constants and FSM state types.
// Imported by the byte receiver, the interface users and the top.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF   = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON    = 4'h9;
  localparam logic [3:0] MIDI_PROG_CHG   = 4'hC;
  localparam logic [3:0] MIDI_CHAN_PRESS = 4'hD;
  localparam logic [7:0] REALTIME_MIN    = 8'hF8;
  localparam logic [7:0] SYSCOM_MIN      = 8'hF0;

  typedef enum logic [2:0] {
    RX_WAIT_IDLE,
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    NO_STATUS,
    WAIT_D1,
    WAIT_D2
  } parse_state_t;

endpackage

// File: rtl/midi_note_receiver_if.sv
// MIDI note bus: serial line in, key/velocity events and framing error out.
// master = receiver side, slave = consumer (trigger logic) side.
interface midi_note_receiver_if;
  logic       midi_din;
  logic [6:0] midi_key;
  logic [6:0] midi_vel;
  logic       midi_dout_valid;
  logic       framing_error;

  modport master (
    input  midi_din,
    output midi_key, midi_vel,
    output midi_dout_valid, framing_error
  );

  modport slave (
    output midi_din,
    input  midi_key, midi_vel,
    input  midi_dout_valid, framing_error
  );
endinterface

// File: rtl/midi_note_receiver_byte_rx.sv
// 8N1 byte receiver: din in; byte_data/byte_valid pulse, framing_error pulse.
// Samples at bit centres; WAIT_IDLE guards against a line held low.
module midi_byte_rx
  import midi_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 3200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_error
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF =
    CNT_W'(CYCLES_PER_BIT / 2 - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RX_WAIT_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      byte_data     <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
      unique case (state)
        RX_WAIT_IDLE: begin
          if (din) state <= RX_IDLE;
        end
        RX_IDLE: begin
          if (!din) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= din ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {din, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (din) begin
              byte_data  <= shreg;
              byte_valid <= 1'b1;
              state      <= RX_IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= RX_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_note_receiver.sv
// MIDI front end: deserializes bytes and parses channel messages with
// running status; pulses key/velocity for Note On with velocity > 0.
module midi_note_receiver
  import midi_pkg::*;
#(
  parameter int         CLK_FREQ_HZ       = 100_000_000,
  parameter int         BAUD              = 31250,
  parameter bit         CHANNEL_FILTER_EN = 1'b0,
  parameter logic [3:0] CHANNEL           = 4'd9
) (
  input logic                  clk,
  input logic                  rst,
  midi_note_receiver_if.master bus
);

  localparam int CYCLES_PER_BIT = CLK_FREQ_HZ / BAUD;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       rx_fe;

  midi_byte_rx #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .din          (bus.midi_din),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .framing_error(rx_fe)
  );

  assign bus.framing_error = rx_fe;

  parse_state_t state;
  logic [7:0]   status;
  logic         rejected;
  logic [6:0]   d1;

  // Byte classes are made mutually exclusive for the one-hot decode.
  logic is_rt, is_sys, is_stat, is_data, one_byte;
  assign is_rt    = byte_data >= REALTIME_MIN;
  assign is_sys   = byte_data >= SYSCOM_MIN && !is_rt;
  assign is_stat  = byte_data[7] && byte_data < SYSCOM_MIN;
  assign is_data  = !byte_data[7];
  assign one_byte = status[7:4] == MIDI_PROG_CHG ||
                    status[7:4] == MIDI_CHAN_PRESS;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= NO_STATUS;
      status              <= '0;
      rejected            <= 1'b0;
      d1                  <= '0;
      bus.midi_key        <= '0;
      bus.midi_vel        <= '0;
      bus.midi_dout_valid <= 1'b0;
    end else begin
      bus.midi_dout_valid <= 1'b0;
      if (byte_valid) begin
        unique case (1'b1)
          is_rt: ;
          is_sys: begin
            state  <= NO_STATUS;
            status <= '0;
          end
          is_stat: begin
            status   <= byte_data;
            rejected <= CHANNEL_FILTER_EN &&
                        byte_data[3:0] != CHANNEL;
            state    <= WAIT_D1;
          end
          is_data: begin
            unique case (state)
              NO_STATUS: ;
              WAIT_D1: begin
                if (!one_byte) begin
                  d1    <= byte_data[6:0];
                  state <= WAIT_D2;
                end
              end
              WAIT_D2: begin
                state <= WAIT_D1;
                if (status[7:4] == MIDI_NOTE_ON && !rejected &&
                    byte_data[6:0] != 7'd0) begin
                  bus.midi_key        <= d1;
                  bus.midi_vel        <= byte_data[6:0];
                  bus.midi_dout_valid <= 1'b1;
                end
              end
              default: state <= NO_STATUS;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_note_receiver.sv
// Scoreboard bench for midi_note_receiver: unfiltered and channel-filtered
// instances share one serial line; monitors pop expected note events.
module tb_midi_note_receiver;
  import midi_pkg::*;

  localparam int CLK_HZ = 500_000;
  localparam int BAUD   = 31250;
  localparam int CPB    = CLK_HZ / BAUD;

  typedef struct { logic [6:0] k; logic [6:0] v; } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   fe0 = 0, fe1 = 0;
  logic bv0_q = 1'b0, bv1_q = 1'b0;
  ev_t  q0[$];
  ev_t  q1[$];

  always #5 clk = ~clk;

  midi_note_receiver_if if0();
  midi_note_receiver_if if1();
  assign if0.midi_din = din;
  assign if1.midi_din = din;

  midi_note_receiver #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD),
    .CHANNEL_FILTER_EN(1'b0), .CHANNEL(4'd9)
  ) dut0 (.clk(clk), .rst(rst), .bus(if0));

  midi_note_receiver #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD),
    .CHANNEL_FILTER_EN(1'b1), .CHANNEL(4'd9)
  ) dut1 (.clk(clk), .rst(rst), .bus(if1));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic mon(input int idx, input logic [6:0] k,
                     input logic [6:0] v, input logic bvp);
    ev_t e;
    chk($sformatf("latency%0d", idx), bvp, 1);
    if ((idx == 0 ? q0.size() : q1.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected%0d: key=%0d vel=%0d, none expected",
               idx, k, v);
    end else begin
      e = (idx == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("key%0d", idx), k, e.k);
      chk($sformatf("vel%0d", idx), v, e.v);
    end
  endtask

  always @(negedge clk) begin
    if (if0.midi_dout_valid)
      mon(0, if0.midi_key, if0.midi_vel, bv0_q);
    if (if1.midi_dout_valid)
      mon(1, if1.midi_key, if1.midi_vel, bv1_q);
    if (if0.framing_error) fe0++;
    if (if1.framing_error) fe1++;
    bv0_q = dut0.u_rx.byte_valid;
    bv1_q = dut1.u_rx.byte_valid;
  end

  task automatic exp_both(input logic [6:0] k, input logic [6:0] v);
    ev_t e;
    e.k = k; e.v = v;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic exp_only0(input logic [6:0] k, input logic [6:0] v);
    ev_t e;
    e.k = k; e.v = v;
    q0.push_back(e);
  endtask

  task automatic bit_time(input logic b);
    din = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_key0"}, if0.midi_key, 0);
    chk({tag, "_vel0"}, if0.midi_vel, 0);
    chk({tag, "_val0"}, if0.midi_dout_valid, 0);
    chk({tag, "_fe0"}, if0.framing_error, 0);
    chk({tag, "_key1"}, if1.midi_key, 0);
    chk({tag, "_val1"}, if1.midi_dout_valid, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    // Line still low from the synchronizer: must not start a frame.
    repeat (CPB) @(negedge clk);
    bit_time(1'b1); bit_time(1'b1);

    exp_both(36, 100);
    send(8'h99); send(8'h24); send(8'h64);

    exp_both(38, 64); exp_both(42, 80);
    send(8'h99); send(8'h26); send(8'h40);
    send(8'h2A); send(8'h50);

    send(8'h99); send(8'h24); send(8'h00);
    send(8'h89); send(8'h24); send(8'h40);
    send(8'h31); send(8'h7F);
    exp_both(49, 127);
    send(8'h99); send(8'h31); send(8'h7F);

    exp_both(46, 32);
    send(8'h99); send(8'h2E); send(8'hF8); send(8'h20);

    send(8'hF0); send(8'h24); send(8'h64);

    exp_only0(36, 100);
    send(8'h90); send(8'h24); send(8'h64);
    exp_both(36, 100);
    send(8'h99); send(8'h24); send(8'h64);

    din = 1'b0;
    repeat (3) @(negedge clk);
    bit_time(1'b1); bit_time(1'b1);

    send(8'h99, 1'b0);
    repeat (20) bit_time(1'b0);
    bit_time(1'b1); bit_time(1'b1);
    exp_both(36, 100);
    send(8'h99); send(8'h24); send(8'h64);

    send(8'h99); send(8'h24);
    bit_time(1'b0); bit_time(1'b0);
    bit_time(1'b0); bit_time(1'b1);
    rst = 1'b1;
    din = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    bit_time(1'b1); bit_time(1'b1);
    send(8'h24); send(8'h64);
    exp_both(36, 100);
    send(8'h99); send(8'h24); send(8'h64);

    bit_time(1'b1); bit_time(1'b1);
    chk("pending0", q0.size(), 0);
    chk("pending1", q1.size(), 0);
    chk("framing0", fe0, 1);
    chk("framing1", fe1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
